// File: rtl/te_block_serializer.sv
// Sink side of the multiple-retirement interface: buffers up to N trace blocks per cycle
// in a circular FIFO and replays them one per cycle, in program order, to a single-port encoder.
package mure_pkg;
  localparam int IRETIRE_LEN = 32;
  localparam int ITYPE_LEN   = 3;
  localparam int CAUSE_LEN   = 5;
  localparam int XLEN        = 32;
  localparam int PRIV_LEN    = 2;

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [XLEN-1:0]        iaddr;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
  } block_t;
endpackage

module te_block_serializer
  import mure_pkg::*;
#(
  parameter int N     = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N-1:0]             valid_i,
  input  logic [N*IRETIRE_LEN-1:0] iretire_i,
  input  logic [N-1:0]             ilastsize_i,
  input  logic [N*ITYPE_LEN-1:0]   itype_i,
  input  logic [N*XLEN-1:0]        iaddr_i,
  input  logic [CAUSE_LEN-1:0]     cause_i,
  input  logic [XLEN-1:0]          tval_i,
  input  logic [PRIV_LEN-1:0]      priv_i,
  output logic                     ready_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [IRETIRE_LEN-1:0]   iretire_o,
  output logic                     ilastsize_o,
  output logic [ITYPE_LEN-1:0]     itype_o,
  output logic [XLEN-1:0]          iaddr_o,
  output logic [CAUSE_LEN-1:0]     cause_o,
  output logic [XLEN-1:0]          tval_o,
  output logic [PRIV_LEN-1:0]      priv_o,
  output logic                     drop_o,
  output logic [CNT_W-1:0]         drop_cnt_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_FW = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);
  localparam logic [CNT_FW-1:0] ROOM = CNT_FW'(DEPTH - N);

  generate
    if (N < 1 || DEPTH < N || (DEPTH & (DEPTH - 1)) != 0) begin : gBadParams
      $error("te_block_serializer: need N >= 1, DEPTH >= N and DEPTH a power of two");
    end
  endgenerate

  block_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic              drop_q;
  logic [CNT_W-1:0]  dropCnt_q, dropCnt_d;

  logic [PTR_W-1:0]  laneOff [N];
  logic [CNT_FW-1:0] npush;
  block_t            laneBlk [N];
  block_t            headBlk;
  logic              push, dropGrp, pop;

  // Each valid lane is written at wrPtr plus the number of valid lanes below it.
  always_comb begin
    logic [CNT_FW-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      laneOff[i] = acc[PTR_W-1:0];
      if (valid_i[i]) acc = acc + CNT_FW'(1);
    end
    npush = acc;
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      laneBlk[i].iretire   = iretire_i[i*IRETIRE_LEN +: IRETIRE_LEN];
      laneBlk[i].ilastsize = ilastsize_i[i];
      laneBlk[i].itype     = itype_i[i*ITYPE_LEN +: ITYPE_LEN];
      laneBlk[i].iaddr     = iaddr_i[i*XLEN +: XLEN];
      laneBlk[i].cause     = cause_i;
      laneBlk[i].tval      = tval_i;
      laneBlk[i].priv      = priv_i;
    end
  end

  assign ready_o = (count_q <= ROOM);
  assign valid_o = (count_q != '0);
  assign push    = (|valid_i) && ready_o;
  assign dropGrp = (|valid_i) && !ready_o;
  assign pop     = valid_o && ready_i;

  always_comb begin
    wrPtr_d   = wrPtr_q + (push ? npush[PTR_W-1:0] : '0);
    rdPtr_d   = rdPtr_q + PTR_W'(pop);
    count_d   = count_q + (push ? npush : '0) - CNT_FW'(pop);
    dropCnt_d = dropCnt_q;
    if (dropGrp && (dropCnt_q != '1)) dropCnt_d = dropCnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      drop_q    <= 1'b0;
      dropCnt_q <= '0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      drop_q    <= dropGrp;
      dropCnt_q <= dropCnt_d;
    end
  end

  // Storage carries no reset; the pointers and count alone decide what is live.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N; i++) begin
      if (push && valid_i[i]) mem_q[(wrPtr_q + laneOff[i]) & PTR_MASK] <= laneBlk[i];
    end
  end

  assign headBlk     = valid_o ? mem_q[rdPtr_q & PTR_MASK] : '0;
  assign iretire_o   = headBlk.iretire;
  assign ilastsize_o = headBlk.ilastsize;
  assign itype_o     = headBlk.itype;
  assign iaddr_o     = headBlk.iaddr;
  assign cause_o     = headBlk.cause;
  assign tval_o      = headBlk.tval;
  assign priv_o      = headBlk.priv;
  assign drop_o      = drop_q;
  assign drop_cnt_o  = dropCnt_q;

endmodule

// File: tb/tb_te_block_serializer.sv
// Scoreboard bench for te_block_serializer: directed groups push expected blocks into a queue,
// an independent negedge monitor pops and compares every block the DUT hands downstream.
module tb_te_block_serializer;
  import mure_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic [N-1:0]             valid_i;
  logic [N*IRETIRE_LEN-1:0] iretire_i;
  logic [N-1:0]             ilastsize_i;
  logic [N*ITYPE_LEN-1:0]   itype_i;
  logic [N*XLEN-1:0]        iaddr_i;
  logic [CAUSE_LEN-1:0]     cause_i;
  logic [XLEN-1:0]          tval_i;
  logic [PRIV_LEN-1:0]      priv_i;
  logic                     ready_o, valid_o, ready_i;
  logic [IRETIRE_LEN-1:0]   iretire_o;
  logic                     ilastsize_o;
  logic [ITYPE_LEN-1:0]     itype_o;
  logic [XLEN-1:0]          iaddr_o;
  logic [CAUSE_LEN-1:0]     cause_o;
  logic [XLEN-1:0]          tval_o;
  logic [PRIV_LEN-1:0]      priv_o;
  logic                     drop_o;
  logic [CNT_W-1:0]         drop_cnt_o;

  block_t outBlk, expBlk, heldBlk;
  block_t expQ[$];
  logic   holdPrev = 1'b0;
  int     vecCount = 0;
  int     missCount = 0;

  te_block_serializer #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .iretire_i(iretire_i),
    .ilastsize_i(ilastsize_i), .itype_i(itype_i), .iaddr_i(iaddr_i), .cause_i(cause_i),
    .tval_i(tval_i), .priv_i(priv_i), .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i),
    .iretire_o(iretire_o), .ilastsize_o(ilastsize_o), .itype_o(itype_o), .iaddr_o(iaddr_o),
    .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o), .drop_o(drop_o), .drop_cnt_o(drop_cnt_o)
  );

  // 10 ns clock; inputs change 1 ns after the rising edge, outputs are checked away from it.
  always #5 clk_i = ~clk_i;

  assign outBlk = {iretire_o, ilastsize_o, itype_o, iaddr_o, cause_o, tval_o, priv_o};

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic block_t mkBlk(input logic [IRETIRE_LEN-1:0] ir, input logic ls,
                                   input logic [ITYPE_LEN-1:0] it, input logic [XLEN-1:0] addr,
                                   input logic [CAUSE_LEN-1:0] cs, input logic [XLEN-1:0] tv,
                                   input logic [PRIV_LEN-1:0] pv);
    block_t b;
    b.iretire = ir; b.ilastsize = ls; b.itype = it; b.iaddr = addr;
    b.cause = cs; b.tval = tv; b.priv = pv;
    return b;
  endfunction

  // Drive one group for one clock; shared fields come from lane 0's block.
  // expAcc is the hand-computed acceptance for the current occupancy.
  task automatic applyStimulus(input string name, input logic [1:0] v, input block_t l0,
                               input block_t l1, input logic expAcc);
    block_t e1;
    valid_i     = v;
    iretire_i   = {l1.iretire, l0.iretire};
    ilastsize_i = {l1.ilastsize, l0.ilastsize};
    itype_i     = {l1.itype, l0.itype};
    iaddr_i     = {l1.iaddr, l0.iaddr};
    cause_i     = l0.cause;
    tval_i      = l0.tval;
    priv_i      = l0.priv;
    checkOutput({name, " ready_o"}, 128'(ready_o), 128'(expAcc));
    if (expAcc) begin
      e1 = l1;
      e1.cause = l0.cause; e1.tval = l0.tval; e1.priv = l0.priv;
      if (v[0]) expQ.push_back(l0);
      if (v[1]) expQ.push_back(e1);
    end
    @(posedge clk_i); #1;
    valid_i = '0;
    checkOutput({name, " drop_o"}, 128'(drop_o), 128'(!expAcc));
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 20; i++) begin
      if (!valid_o) break;
      @(posedge clk_i); #1;
    end
    checkOutput({name, " drained valid_o"}, 128'(valid_o), 128'(0));
    checkOutput({name, " scoreboard empty"}, 128'(expQ.size()), 128'(0));
  endtask

  // Monitor: pops the scoreboard on every handshake, checks idle zeroing and hold stability.
  always @(negedge clk_i) begin
    if (rst_i) begin
      holdPrev = 1'b0;
    end else begin
      if (valid_o && ready_i) begin
        if (expQ.size() == 0) begin
          vecCount++;
          missCount++;
          $display("[TB] FAIL unexpected block: got %h, expected none", outBlk);
        end else begin
          expBlk = expQ.pop_front();
          checkOutput("block order/content", 128'(outBlk), 128'(expBlk));
        end
      end else if (!valid_o) begin
        checkOutput("idle fields zero", 128'(outBlk), 128'(0));
      end
      if (holdPrev && valid_o) checkOutput("hold stable", 128'(outBlk), 128'(heldBlk));
      holdPrev = valid_o && !ready_i;
      heldBlk  = outBlk;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    block_t a, b;
    rst_i = 1'b1; ready_i = 1'b0; valid_i = '0;
    iretire_i = '0; ilastsize_i = '0; itype_i = '0; iaddr_i = '0;
    cause_i = '0; tval_i = '0; priv_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset valid_o", 128'(valid_o), 128'(0));
    checkOutput("reset ready_o", 128'(ready_o), 128'(1));
    checkOutput("reset drop_cnt_o", 128'(drop_cnt_o), 128'(0));
    checkOutput("reset drop_o", 128'(drop_o), 128'(0));
    checkOutput("reset fields", 128'(outBlk), 128'(0));

    $display("[TB] single lane");
    ready_i = 1'b1;
    a = mkBlk(32'd4, 1'b1, 3'd2, 32'h8000_0000, 5'd0, 32'h0, 2'd3);
    b = mkBlk(32'd7, 1'b0, 3'd5, 32'h0000_DEAD, 5'd0, 32'h0, 2'd3);
    applyStimulus("single", 2'b01, a, b, 1'b1);
    checkOutput("single valid_o next cycle", 128'(valid_o), 128'(1));
    checkOutput("single itype_o", 128'(itype_o), 128'(2));
    checkOutput("single iaddr_o", 128'(iaddr_o), 128'(32'h8000_0000));
    checkOutput("single priv_o", 128'(priv_o), 128'(3));
    @(posedge clk_i); #1;
    checkOutput("single valid_o after pop", 128'(valid_o), 128'(0));

    $display("[TB] two lanes");
    a = mkBlk(32'd2, 1'b0, 3'd1, 32'h100, 5'd5, 32'h1234, 2'd1);
    b = mkBlk(32'd3, 1'b1, 3'd4, 32'h200, 5'd5, 32'h1234, 2'd1);
    applyStimulus("pair", 2'b11, a, b, 1'b1);
    checkOutput("pair first iaddr_o", 128'(iaddr_o), 128'(32'h100));
    checkOutput("pair first cause_o", 128'(cause_o), 128'(5));
    @(posedge clk_i); #1;
    checkOutput("pair second iaddr_o", 128'(iaddr_o), 128'(32'h200));
    checkOutput("pair second cause_o", 128'(cause_o), 128'(5));
    waitDrain("pair");

    $display("[TB] compaction");
    a = mkBlk(32'd9, 1'b0, 3'd6, 32'hBAD0, 5'd1, 32'h0, 2'd0);
    b = mkBlk(32'd1, 1'b1, 3'd3, 32'h300, 5'd1, 32'h0, 2'd0);
    applyStimulus("compact", 2'b10, a, b, 1'b1);
    checkOutput("compact iaddr_o", 128'(iaddr_o), 128'(32'h300));
    @(posedge clk_i); #1;
    waitDrain("compact");

    $display("[TB] backpressure and drop");
    ready_i = 1'b0;
    applyStimulus("bp g1", 2'b11, mkBlk(32'd10, 1'b0, 3'd1, 32'h1000, 5'd2, 32'hA, 2'd1),
                  mkBlk(32'd11, 1'b1, 3'd2, 32'h1004, 5'd2, 32'hA, 2'd1), 1'b1);
    applyStimulus("bp g2", 2'b11, mkBlk(32'd12, 1'b0, 3'd3, 32'h1008, 5'd3, 32'hB, 2'd3),
                  mkBlk(32'd13, 1'b1, 3'd4, 32'h100C, 5'd3, 32'hB, 2'd3), 1'b1);
    checkOutput("bp full ready_o", 128'(ready_o), 128'(0));
    applyStimulus("bp g3", 2'b11, mkBlk(32'd14, 1'b0, 3'd5, 32'h1010, 5'd4, 32'hC, 2'd0),
                  mkBlk(32'd15, 1'b1, 3'd6, 32'h1014, 5'd4, 32'hC, 2'd0), 1'b0);
    checkOutput("bp drop_cnt_o", 128'(drop_cnt_o), 128'(1));
    @(posedge clk_i); #1;
    checkOutput("bp drop_o single pulse", 128'(drop_o), 128'(0));
    checkOutput("bp drop_cnt_o held", 128'(drop_cnt_o), 128'(1));
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("bp count3 ready_o", 128'(ready_o), 128'(0));
    @(posedge clk_i); #1;
    checkOutput("bp count2 ready_o", 128'(ready_o), 128'(1));
    waitDrain("bp");

    $display("[TB] wrap with simultaneous push/pop");
    applyStimulus("wrap w", 2'b01, mkBlk(32'd20, 1'b0, 3'd0, 32'h2000, 5'd6, 32'h0, 2'd1),
                  mkBlk(32'd0, 1'b0, 3'd0, 32'h0, 5'd6, 32'h0, 2'd1), 1'b1);
    waitDrain("wrap w");
    ready_i = 1'b0;
    applyStimulus("wrap xy", 2'b11, mkBlk(32'd21, 1'b1, 3'd1, 32'h2100, 5'd7, 32'h11, 2'd2),
                  mkBlk(32'd22, 1'b0, 3'd2, 32'h2104, 5'd7, 32'h11, 2'd2), 1'b1);
    ready_i = 1'b1;
    applyStimulus("wrap z", 2'b11, mkBlk(32'd23, 1'b1, 3'd3, 32'h2200, 5'd8, 32'h22, 2'd3),
                  mkBlk(32'd24, 1'b0, 3'd4, 32'h2204, 5'd8, 32'h22, 2'd3), 1'b1);
    checkOutput("wrap count3 ready_o", 128'(ready_o), 128'(0));
    waitDrain("wrap");

    $display("[TB] mid-operation reset");
    ready_i = 1'b0;
    applyStimulus("stale g1", 2'b11, mkBlk(32'd30, 1'b0, 3'd1, 32'h3000, 5'd9, 32'h33, 2'd0),
                  mkBlk(32'd31, 1'b1, 3'd2, 32'h3004, 5'd9, 32'h33, 2'd0), 1'b1);
    applyStimulus("stale g2", 2'b01, mkBlk(32'd32, 1'b0, 3'd3, 32'h3008, 5'd10, 32'h44, 2'd1),
                  mkBlk(32'd0, 1'b0, 3'd0, 32'h0, 5'd10, 32'h44, 2'd1), 1'b1);
    checkOutput("stale stored valid_o", 128'(valid_o), 128'(1));
    rst_i = 1'b1;
    expQ.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    checkOutput("midreset valid_o", 128'(valid_o), 128'(0));
    checkOutput("midreset ready_o", 128'(ready_o), 128'(1));
    checkOutput("midreset drop_cnt_o", 128'(drop_cnt_o), 128'(0));
    ready_i = 1'b1;
    repeat (6) @(posedge clk_i);
    #1;
    checkOutput("midreset no stale valid_o", 128'(valid_o), 128'(0));
    checkOutput("midreset scoreboard empty", 128'(expQ.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/te_block_serializer.md
Name: te_block_serializer

Overview:
- Sink side of the multiple-retirement interface.
- Accepts up to N trace-encoder blocks per cycle: iretire, ilastsize, itype and iaddr per lane, plus shared cause, tval and priv.
- Buffers the blocks in a circular FIFO and emits them one per cycle, in program order, to a single-block trace encoder that uses a valid/ready handshake.
- Sits between the multiple_retirement stage and the single-port encoder core.

Parameters:
- N, 2, number of input block lanes (≥1).
- DEPTH, 4, FIFO entries, one block each; power of two, DEPTH ≥ N; checked by an elaboration assertion.
- CNT_W, 16, width of the saturating drop counter.
- Block field widths IRETIRE_LEN, ITYPE_LEN, CAUSE_LEN, XLEN, PRIV_LEN come from mure_pkg.

Ports:
- clk_i in 1: clock, all logic on the rising edge.
- rst_i in 1: reset, synchronous, active-high.
- valid_i in N: per-lane block valid.
- iretire_i in N×IRETIRE_LEN: per-lane retired half-word count.
- ilastsize_i in N: per-lane size of the last instruction.
- itype_i in N×ITYPE_LEN: per-lane block type.
- iaddr_i in N×XLEN: per-lane block start address.
- cause_i in CAUSE_LEN: shared exception/interrupt cause.
- tval_i in XLEN: shared trap value.
- priv_i in PRIV_LEN: shared privilege level.
- ready_o out 1: the FIFO can absorb a full N-block group.
- valid_o out 1: output block valid.
- ready_i in 1: downstream accepts the output block.
- iretire_o out IRETIRE_LEN: head block iretire.
- ilastsize_o out 1: head block ilastsize.
- itype_o out ITYPE_LEN: head block itype.
- iaddr_o out XLEN: head block iaddr.
- cause_o out CAUSE_LEN: head block cause.
- tval_o out XLEN: head block tval.
- priv_o out PRIV_LEN: head block priv.
- drop_o out 1: one-cycle pulse when an input group was discarded.
- drop_cnt_o out CNT_W: saturating count of discarded groups.

Behaviour:
- Reset (rst_i=1 at a rising edge):
  - Write pointer, read pointer and count go to 0; drop_o=0; drop_cnt_o=0.
  - FIFO storage is not reset.
  - A reset mid-operation flushes all buffered blocks immediately.
  - In the first cycle after reset: valid_o=0, ready_o=1.
- Storage: each entry holds {iretire, ilastsize, itype, iaddr, cause, tval, priv}. Shared cause/tval/priv are copied into every entry written from the same group.
- ready_o = ((DEPTH − count) ≥ N).
  - Depends on registered count only; it has no combinational path from ready_i or valid_i.
- Push:
  - A group is accepted when |valid_i && ready_o.
  - Valid lanes are compacted in ascending lane order (lane 0 first) and invalid lanes are skipped.
  - npush = popcount(valid_i).
  - Entries are written at wr_ptr … wr_ptr+npush−1, modulo DEPTH; then wr_ptr += npush.
- Drop:
  - A group is discarded whole, with no partial write, when |valid_i && !ready_o.
  - The next cycle drop_o=1.
  - drop_cnt_o increments by 1 and saturates at 2^CNT_W−1.
- Output (show-ahead):
  - valid_o = (count ≠ 0); o-fields show the head entry at rd_ptr.
  - All o-fields are forced to 0 when valid_o=0.
- Pop: when valid_o && ready_i, rd_ptr += 1 (wraps modulo DEPTH).
- Count: count_next = count + (accepted ? npush : 0) − pop.
  - Simultaneous push and pop are legal in the same cycle.
  - Count never exceeds DEPTH and never underflows.
- Latency: a block accepted at edge k appears on the outputs at the earliest after edge k, i.e. one cycle. Blocks leave at one per cycle while ready_i=1.
- Ordering: output order equals input order, lane 0 before lane 1 within a group, earlier groups first.
- Stability: while valid_o=1 and ready_i=0, all o-fields hold stable.
- Empty with push in the same cycle: no bypass; valid_o rises the next cycle.
- Full (count=DEPTH): ready_o=0 and no pop occurs unless ready_i=1.
- Wrap-around: pointer arithmetic is modulo DEPTH; a group may straddle the wrap.

Test Plan:
1. Reset: hold rst_i=1 for 3 cycles, then release → valid_o=0, ready_o=1, drop_cnt_o=0, all o-fields 0.
2. Single lane: valid_i=01, itype_i[0]=2, iaddr_i[0]=0x80000000, priv_i=3, ready_i=1 → next cycle valid_o=1, itype_o=2, iaddr_o=0x80000000, priv_o=3; the cycle after that, valid_o=0.
3. Two lanes: valid_i=11, iaddr 0x100 (lane 0) and 0x200 (lane 1), cause_i=5 → iaddr_o=0x100 then 0x200 on consecutive cycles, cause_o=5 on both.
4. Compaction: valid_i=10, lane 1 iaddr=0x300 → exactly one output block with iaddr_o=0x300.
5. Backpressure and drop (DEPTH=4, N=2):
   - Hold ready_i=0 and push 2 full groups → ready_o=0.
   - Push a 3rd group → it is discarded, drop_o pulses once, drop_cnt_o=1.
   - Raise ready_i → the 4 stored blocks emerge in order; ready_o=1 again once count ≤ 2.
6. Wrap, simultaneous push/pop, mid-operation reset:
   - At count=2, ready_i=1, push valid_i=11 → count becomes 3, order is preserved across the pointer wrap.
   - Assert rst_i with 3 blocks stored → valid_o=0 the next cycle and none of the stale blocks reappear.
